// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: op encoding, FSM states, defaults.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // ADD and SUB share op[1]=1; only those ops report carry/borrow and overflow.
  function automatic logic is_arith(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational 1-bit ALU slice: NOR, XOR, full add, full subtract (cout = borrow).
module serial_alu_slice
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);

  always_comb begin
    s    = 1'b0;
    cout = 1'b0;
    case (op_e'(op))
      OP_NOR: s = ~(a | b);
      OP_XOR: s = a ^ b;
      OP_ADD: begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      OP_SUB: begin
        s    = a ^ b ^ cin;
        cout = (~a & b) | (~a & cin) | (b & cin);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_alu_top.sv
// Integration wrapper: sequencer plus its 1-bit slice as a complete multi-cycle ALU.
// Exposes ovf when SERIAL_ALU_OVF_EN is defined.
module serial_alu_top
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_out
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic       alu_a, alu_b, alu_cin, alu_s, alu_cout;
  logic [1:0] alu_op;

  serial_alu_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .op       (op),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout_out (cout_out),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_op   (alu_op),
    .alu_s    (alu_s),
    .alu_cout (alu_cout)
`ifdef SERIAL_ALU_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  serial_alu_slice u_slice (
    .a    (alu_a),
    .b    (alu_b),
    .cin  (alu_cin),
    .op   (alu_op),
    .s    (alu_s),
    .cout (alu_cout)
  );

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer driving a 1-bit ALU slice, LSB first, WIDTH cycles per op.
// Optional signed-overflow output enabled by defining SERIAL_ALU_OVF_EN.
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_out,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic             alu_s,
  input  logic             alu_cout
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_bit;
`ifdef SERIAL_ALU_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    // NOTE: every _d starts at its held value so no path through the case leaves a latch.
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ALU_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = op_e'(op);
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {alu_s, res_q[WIDTH-1:1]};
        carry_d = alu_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          cnt_d   = '0;
          cout_d  = is_arith(op_q) & alu_cout;
`ifdef SERIAL_ALU_OVF_EN
          // Signed overflow: carry into the MSB differs from carry out of it.
          ovf_d   = is_arith(op_q) & (carry_q ^ alu_cout);
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_NOR;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = res_q;
  assign cout_out = cout_q;
  assign alu_a    = (state_q == RUN) & a_q[0];
  assign alu_b    = (state_q == RUN) & b_q[0];
  assign alu_cin  = (state_q == RUN) & carry_q;
  assign alu_op   = op_q;
`ifdef SERIAL_ALU_OVF_EN
  assign ovf      = ovf_q;
`endif

endmodule

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
Bit-serial sequencer that sits directly upstream of the 1-bit ALU slice and consumes its outputs.
- Latches two WIDTH-bit operands and a 2-bit op, then streams one bit pair per clock (LSB first) into the slice.
- Registers the slice carry/borrow between cycles and shifts the slice sum bit into a result register.
- Turns the combinational slice into a WIDTH-cycle multi-bit ALU (NOR, XOR, ADD, SUB).

Parameters:
WIDTH, 8, operand/result width in bits (2..32)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request pulse; sampled only when not busy
a_in  input  WIDTH  operand A, sampled with start
b_in  input  WIDTH  operand B, sampled with start
op  input  2  00=NOR, 01=XOR, 10=ADD, 11=SUB, sampled with start
busy  output  1  high while bits are being streamed
done  output  1  one-cycle pulse when result is valid
result  output  WIDTH  final result, held until next accepted start
cout_out  output  1  final carry (ADD) or borrow (SUB); 0 for NOR/XOR
alu_a  output  1  bit to slice input a
alu_b  output  1  bit to slice input b
alu_cin  output  1  carry/borrow to slice cin
alu_op  output  2  latched op to slice op
alu_s  input  1  slice sum/logic output
alu_cout  input  1  slice carry/borrow output

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n). All state updates on the rising clk edge.
- Reset values (rst_n low at an edge): state=IDLE, busy=0, done=0, result=0, cout_out=0, carry flop=0, bit counter=0, operand shift registers=0, latched op=00.
- Reset mid-operation: aborts immediately. At the next edge the block is in IDLE with no done pulse, and result is cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. alu_a, alu_b and alu_cin are driven 0.
  - start=1: load a_in/b_in into shift registers, latch op, clear the carry flop and counter, go to RUN.
- RUN: busy=1. alu_a = LSB of A register, alu_b = LSB of B register, alu_cin = carry flop, alu_op = latched op.
  - Each edge: shift A and B right by one; shift alu_s into the MSB of the result shift register; carry flop <= alu_cout; counter++.
  - After the WIDTH-th bit edge (counter = WIDTH-1 at that edge): result takes its final value, cout_out <= alu_cout for ADD/SUB (0 for NOR/XOR), go to DONE.
- DONE: done=1 for exactly one cycle, busy=0.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, direct to RUN).
  - Otherwise go to IDLE.
- Latency: start sampled at edge 0 → busy=1 after edge 0 through edge WIDTH → done=1 during the cycle after edge WIDTH. Back-to-back throughput is one operation per WIDTH+1 cycles.
- start while busy: ignored; operands and op are not re-sampled.
- Arithmetic rules:
  - ADD: result = (A+B) mod 2^WIDTH; cout_out = carry out of the MSB.
  - SUB: result = (A−B) mod 2^WIDTH; cout_out = borrow out of the MSB (1 iff A<B unsigned). The slice's SUB contract is s=a^b^cin, cout=borrow.
  - Initial carry/borrow is 0 for all ops. For NOR/XOR the carry flop is updated but ignored.
- Timing: the alu_a → alu_s path is combinational through the slice. The clk period must exceed the slice worst-case gate delay (≥40 time units with the team cell library delays).

Optional Feature:
- Macro: SERIAL_ALU_OVF_EN.
- Defined: adds output port ovf (1 bit), reset 0. At the MSB bit edge, for ADD/SUB, ovf <= alu_cin XOR alu_cout (signed overflow); for NOR/XOR ovf <= 0. ovf is held with result until the next accepted start.
- Undefined: no ovf port and no related logic.

Decomposition:
- Package serial_alu_pkg holds:
  - enum op_e: OP_NOR=2'b00, OP_XOR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11.
  - enum state_e: IDLE, RUN, DONE.
  - localparam DEFAULT_WIDTH=8.
- No internal sub-module; the counter and shift registers stay inline.
- Integration/test wrapper serial_alu_top instantiates serial_alu_ctrl plus the 1-bit slice and wires the alu_* ports.

Test Plan:
- WIDTH=8, ADD: 0x35+0x4A → result=0x7F, cout_out=0; done exactly 9 cycles after start edge. ADD 0xFF+0x01 → 0x00, cout_out=1.
- SUB: 0x10−0x01 → 0x0F, cout_out=0. SUB 0x00−0x01 → 0xFF, cout_out=1.
- NOR 0xF0,0x0C → 0x03, cout_out=0. XOR 0xAA,0xFF → 0x55, cout_out=0.
- start pulsed again mid-RUN with different operands → ignored; first result unchanged. start during DONE → second op runs back-to-back and gives the correct result.
- rst_n low for one edge at bit 3 of RUN → next cycle busy=0, result=0, no done pulse. A fresh op afterwards is correct.
- SERIAL_ALU_OVF_EN defined: ADD 0x7F+0x01 → 0x80, ovf=1. SUB 0x80−0x01 → 0x7F, ovf=1. ADD 0x01+0x01 → ovf=0.
